// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch traceback controller: sizes, direction codes,
// nucleotide encodings and FSM state constants.
package nw_pkg;
  localparam int unsigned N     = 128;
  localparam int unsigned IDX_W = $clog2(N + 1);
  localparam int unsigned LEN_W = $clog2(2 * N + 1);

  localparam logic [2:0] DIR_DIAG = 3'b001;
  localparam logic [2:0] DIR_LEFT = 3'b100;
  localparam logic [2:0] DIR_UP   = 3'b010;
  localparam logic [2:0] DASH     = 3'b111;

  localparam logic [2:0] NT_A = 3'b000;
  localparam logic [2:0] NT_C = 3'b001;
  localparam logic [2:0] NT_G = 3'b010;
  localparam logic [2:0] NT_T = 3'b011;
  localparam logic [2:0] NT_N = 3'b100;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_EMIT   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

  function automatic logic dir_legal(input logic [2:0] code);
    return (code == DIR_DIAG) || (code == DIR_LEFT) || (code == DIR_UP);
  endfunction
endpackage

// File: rtl/nw_traceback_ctrl_if.sv
// Control, memory-read and column-output signals of the traceback controller.
interface nw_traceback_ctrl_if;
  logic                        start;
  logic [nw_pkg::IDX_W-1:0]    len_a;
  logic [nw_pkg::IDX_W-1:0]    len_b;
  logic                        dir_rd_en;
  logic [nw_pkg::IDX_W-1:0]    dir_i;
  logic [nw_pkg::IDX_W-1:0]    dir_j;
  logic [2:0]                  dir_data;
  logic                        seq_rd_en;
  logic [nw_pkg::IDX_W-1:0]    seqA_addr;
  logic [nw_pkg::IDX_W-1:0]    seqB_addr;
  logic [2:0]                  seqA_data;
  logic [2:0]                  seqB_data;
  logic [2:0]                  symbol_out;
  logic [2:0]                  seqA_out;
  logic [2:0]                  seqB_out;
  logic                        step_valid;
  logic                        busy;
  logic                        done;
  logic                        err;
  logic [nw_pkg::LEN_W-1:0]    align_len;

  modport master (
    input  start, len_a, len_b, dir_data, seqA_data, seqB_data,
    output dir_rd_en, dir_i, dir_j, seq_rd_en, seqA_addr, seqB_addr,
           symbol_out, seqA_out, seqB_out, step_valid, busy, done, err, align_len
  );

  modport slave (
    output start, len_a, len_b, dir_data, seqA_data, seqB_data,
    input  dir_rd_en, dir_i, dir_j, seq_rd_en, seqA_addr, seqB_addr,
           symbol_out, seqA_out, seqB_out, step_valid, busy, done, err, align_len
  );
endinterface

// File: rtl/nw_traceback_ctrl_idx_walker.sv
// i/j down-counters for the traceback walk; forces left/up moves on the matrix edges so
// the indices can never underflow.
module nw_idx_walker
  import nw_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             adv,
  input  logic [IDX_W-1:0] len_a,
  input  logic [IDX_W-1:0] len_b,
  input  logic [2:0]       dir_code,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic [IDX_W-1:0] i_nxt_c,
  output logic [IDX_W-1:0] j_nxt_c,
  output logic [2:0]       sym_c,
  output logic             legal_c
);

  // Edge rows/columns have only one legal move, whatever the memory says.
  always_comb begin
    sym_c = dir_code;
    if (i == '0 && j != '0)      sym_c = DIR_LEFT;
    else if (j == '0 && i != '0) sym_c = DIR_UP;
    legal_c = dir_legal(sym_c);
  end

  always_comb begin
    i_nxt_c = i;
    j_nxt_c = j;
    if (load) begin
      i_nxt_c = len_a;
      j_nxt_c = len_b;
    end else if (adv) begin
      case (sym_c)
        DIR_DIAG: begin
          i_nxt_c = i - IDX_W'(1);
          j_nxt_c = j - IDX_W'(1);
        end
        DIR_LEFT: j_nxt_c = j - IDX_W'(1);
        DIR_UP:   i_nxt_c = i - IDX_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i <= '0;
      j <= '0;
    end else begin
      i <= i_nxt_c;
      j <= j_nxt_c;
    end
  end

endmodule

// File: rtl/nw_traceback_ctrl.sv
// Needleman-Wunsch traceback sequencer: walks the direction matrix from (len_a,len_b)
// to (0,0), emitting one aligned column every three cycles.
module nw_traceback_ctrl
  import nw_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  nw_traceback_ctrl_if.master bus
);

  logic [2:0]       state_q, state_nxt;
  logic [IDX_W-1:0] i_q, j_q, i_nxt, j_nxt;
  logic [2:0]       sym_c;
  logic             legal_c, load_c, adv_c, origin_nxt_c;
  logic [2:0]       dir_q, seqa_q, seqb_q;

  assign load_c       = (state_q == ST_IDLE) && bus.start;
  assign adv_c        = (state_q == ST_EMIT) && legal_c;
  assign origin_nxt_c = (i_nxt == '0) && (j_nxt == '0);

  nw_idx_walker u_walker (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .adv      (adv_c),
    .len_a    (bus.len_a),
    .len_b    (bus.len_b),
    .dir_code (dir_q),
    .i        (i_q),
    .j        (j_q),
    .i_nxt_c  (i_nxt),
    .j_nxt_c  (j_nxt),
    .sym_c    (sym_c),
    .legal_c  (legal_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = (i_q == '0 && j_q == '0) ? ST_FINISH : ST_WAIT;
      ST_WAIT:   state_nxt = ST_EMIT;
      ST_EMIT:   state_nxt = legal_c ? ST_FETCH : ST_ERROR;
      ST_FINISH: state_nxt = ST_IDLE;
      ST_ERROR:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Memory read data is only valid in WAIT; hold it for the EMIT decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q  <= '0;
      seqa_q <= '0;
      seqb_q <= '0;
    end else if (state_q == ST_WAIT) begin
      dir_q  <= bus.dir_data;
      seqa_q <= bus.seqA_data;
      seqb_q <= bus.seqB_data;
    end
  end

  // Outputs are registered from the next state so strobes line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dir_rd_en  <= 1'b0;
      bus.seq_rd_en  <= 1'b0;
      bus.dir_i      <= '0;
      bus.dir_j      <= '0;
      bus.seqA_addr  <= '0;
      bus.seqB_addr  <= '0;
      bus.symbol_out <= '0;
      bus.seqA_out   <= '0;
      bus.seqB_out   <= '0;
      bus.step_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.align_len  <= '0;
    end else begin
      bus.dir_rd_en  <= (state_nxt == ST_FETCH) && !origin_nxt_c;
      bus.seq_rd_en  <= (state_nxt == ST_FETCH) && !origin_nxt_c;
      if (state_nxt == ST_FETCH) begin
        bus.dir_i     <= i_nxt;
        bus.dir_j     <= j_nxt;
        bus.seqA_addr <= i_nxt - IDX_W'(1);
        bus.seqB_addr <= j_nxt - IDX_W'(1);
      end
      bus.busy       <= (state_nxt == ST_FETCH) || (state_nxt == ST_WAIT) ||
                        (state_nxt == ST_EMIT);
      bus.done       <= (state_nxt == ST_FINISH) || (state_nxt == ST_ERROR);
      bus.step_valid <= adv_c;
      if (adv_c) begin
        bus.symbol_out <= sym_c;
        bus.seqA_out   <= seqa_q;
        bus.seqB_out   <= seqb_q;
      end
      if (load_c)                       bus.err <= 1'b0;
      else if (state_nxt == ST_ERROR)   bus.err <= 1'b1;
      if (load_c)     bus.align_len <= '0;
      else if (adv_c) bus.align_len <= bus.align_len + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_nw_traceback_ctrl.sv
// Self-checking bench for nw_traceback_ctrl: memory responder, spec-level walk model,
// directed and randomized scenarios.
module tb_nw_traceback_ctrl;
  import nw_pkg::*;

  typedef struct {
    logic [2:0] sym;
    logic [2:0] a;
    logic [2:0] b;
    int         rel;
  } step_t;

  logic clk;
  logic rst;
  int   cyc;
  int   start_cyc;
  int   errors;
  int   checks;

  logic [2:0] dir_mem [0:128][0:128];
  logic [2:0] seqa_mem [0:255];
  logic [2:0] seqb_mem [0:255];

  step_t got_q[$];
  step_t exp_q[$];

  nw_traceback_ctrl_if bus();

  nw_traceback_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memories with one cycle of read latency; data is scrambled when no read was issued.
  always @(posedge clk) begin
    if (bus.dir_rd_en)
      bus.dir_data <= (bus.dir_i <= 8'd128 && bus.dir_j <= 8'd128) ?
                      dir_mem[bus.dir_i][bus.dir_j] : 3'($urandom);
    else
      bus.dir_data <= 3'($urandom);
    if (bus.seq_rd_en) begin
      bus.seqA_data <= seqa_mem[bus.seqA_addr];
      bus.seqB_data <= seqb_mem[bus.seqB_addr];
    end else begin
      bus.seqA_data <= 3'($urandom);
      bus.seqB_data <= 3'($urandom);
    end
  end

  always @(negedge clk) begin
    if (bus.step_valid) begin
      step_t s;
      s.sym = bus.symbol_out;
      s.a   = bus.seqA_out;
      s.b   = bus.seqB_out;
      s.rel = cyc - start_cyc;
      got_q.push_back(s);
    end
  end

  task automatic fill_dir(input logic [2:0] code);
    for (int r = 0; r <= 128; r++)
      for (int c = 0; c <= 128; c++) dir_mem[r][c] = code;
  endtask

  task automatic fill_dir_random(input int bad_pct);
    for (int r = 0; r <= 128; r++)
      for (int c = 0; c <= 128; c++) begin
        if ($urandom_range(99, 0) < bad_pct) dir_mem[r][c] = 3'b000;
        else case ($urandom_range(2, 0))
          0: dir_mem[r][c] = 3'b001;
          1: dir_mem[r][c] = 3'b100;
          default: dir_mem[r][c] = 3'b010;
        endcase
      end
  endtask

  task automatic fill_seq();
    for (int k = 0; k < 256; k++) begin
      seqa_mem[k] = 3'($urandom);
      seqb_mem[k] = 3'($urandom);
    end
  endtask

  // Reference walk: one column per step, edges forced, illegal code ends the walk.
  task automatic model(input int la, input int lb, output int n, output bit e);
    int i;
    int j;
    logic [2:0] c;
    step_t s;
    i = la;
    j = lb;
    n = 0;
    e = 1'b0;
    exp_q.delete();
    while (i > 0 || j > 0) begin
      if (i == 0)      c = 3'b100;
      else if (j == 0) c = 3'b010;
      else             c = dir_mem[i][j];
      if (c != 3'b001 && c != 3'b100 && c != 3'b010) begin
        e = 1'b1;
        break;
      end
      s.sym = c;
      s.a   = seqa_mem[8'(i - 1)];
      s.b   = seqb_mem[8'(j - 1)];
      s.rel = 4 + 3 * n;
      exp_q.push_back(s);
      n++;
      if (c == 3'b001) begin i--; j--; end
      else if (c == 3'b100) j--;
      else i--;
    end
  endtask

  task automatic run_walk(input string name, input int la, input int lb, input bit glitch);
    int  n;
    bit  e;
    int  exp_done;
    bit  found;
    int  m;
    model(la, lb, n, e);
    exp_done = e ? 3 * n + 4 : 3 * n + 2;
    got_q.delete();
    @(negedge clk);
    bus.len_a = 8'(la);
    bus.len_b = 8'(lb);
    bus.start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL %s busy/err after start: got busy=%b err=%b want busy=1 err=0",
               name, bus.busy, bus.err);
    end
    found = 1'b0;
    for (int k = 0; k < exp_done + 30 && !found; k++) begin
      if (bus.done === 1'b1) found = 1'b1;
      else begin
        bus.start = glitch && (cyc - start_cyc == 7);
        if (bus.start) begin
          bus.len_a = 8'($urandom_range(128, 0));
          bus.len_b = 8'($urandom_range(128, 0));
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s done timeout: no done within %0d cycles, want done at %0d",
               name, exp_done + 30, exp_done);
      return;
    end
    checks++;
    if (cyc - start_cyc != exp_done) begin
      errors++;
      $display("FAIL %s done latency: got %0d want %0d", name, cyc - start_cyc, exp_done);
    end
    checks++;
    if (bus.align_len !== LEN_W'(n) || bus.err !== e || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end status: got len=%0d err=%b busy=%b want len=%0d err=%b busy=0",
               name, bus.align_len, bus.err, bus.busy, n, e);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s step count: got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < m; k++) begin
      checks++;
      if (got_q[k].sym !== exp_q[k].sym || got_q[k].a !== exp_q[k].a ||
          got_q[k].b !== exp_q[k].b || got_q[k].rel != exp_q[k].rel) begin
        errors++;
        $display("FAIL %s step %0d: got sym=%b a=%b b=%b cyc=%0d want sym=%b a=%b b=%b cyc=%0d",
                 name, k, got_q[k].sym, got_q[k].a, got_q[k].b, got_q[k].rel,
                 exp_q[k].sym, exp_q[k].a, exp_q[k].b, exp_q[k].rel);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.align_len !== LEN_W'(n) || bus.err !== e) begin
      errors++;
      $display("FAIL %s after done: got done=%b len=%0d err=%b want done=0 len=%0d err=%b",
               name, bus.done, bus.align_len, bus.err, n, e);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {bus.dir_rd_en, bus.seq_rd_en, bus.dir_i, bus.dir_j, bus.seqA_addr, bus.seqB_addr,
            bus.symbol_out, bus.seqA_out, bus.seqB_out, bus.step_valid, bus.busy, bus.done,
            bus.err, bus.align_len};
  endfunction

  task automatic test_reset();
    checks++;
    if (out_vec() !== 64'd0) begin
      errors++;
      $display("FAIL reset outputs: got %h want 0", out_vec());
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.align_len !== '0) begin
      errors++;
      $display("FAIL reset status: got busy=%b done=%b len=%0d want 0 0 0",
               bus.busy, bus.done, bus.align_len);
    end
  endtask

  task automatic test_diag();
    fill_dir(3'b001);
    fill_seq();
    run_walk("diag3x3", 3, 3, 1'b0);
  endtask

  task automatic test_up_only();
    fill_dir(3'b000);
    run_walk("up2x0", 2, 0, 1'b0);
  endtask

  task automatic test_zero();
    run_walk("zero", 0, 0, 1'b0);
  endtask

  task automatic test_mixed();
    fill_dir(3'b000);
    dir_mem[2][2] = 3'b100;
    dir_mem[2][1] = 3'b010;
    dir_mem[1][1] = 3'b001;
    run_walk("mixed", 2, 2, 1'b0);
  endtask

  task automatic test_error();
    fill_dir(3'b001);
    dir_mem[3][3] = 3'b000;
    run_walk("illegal", 3, 3, 1'b0);
    dir_mem[3][3] = 3'b001;
    run_walk("after_err", 3, 3, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    fill_dir(3'b001);
    @(negedge clk);
    bus.len_a = 8'd3;
    bus.len_b = 8'd3;
    bus.start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc - start_cyc < 5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_vec() !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid outputs: got %h want 0", out_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.step_valid !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL reset_mid activity: got done/busy/step after reset, want idle");
    end
    run_walk("post_reset", 3, 3, 1'b0);
  endtask

  task automatic test_boundary();
    fill_seq();
    fill_dir(3'b100);
    run_walk("max_len", 128, 128, 1'b1);
    fill_dir(3'b001);
    run_walk("max_diag", 128, 128, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      fill_dir_random(4);
      fill_seq();
      run_walk("random", $urandom_range(12, 0), $urandom_range(12, 0), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    fill_dir_random(0);
    run_walk("b2b_a", 5, 4, 1'b0);
    run_walk("b2b_b", 4, 6, 1'b0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    start_cyc = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.len_a = '0;
    bus.len_b = '0;
    fill_dir(3'b001);
    fill_seq();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_diag();
    test_up_only();
    test_zero();
    test_mixed();
    test_error();
    test_reset_mid();
    test_boundary();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
